seg_scan_decoder: RTL and testbench

//   Receive end of the multiplexed seven-segment interface: snoops a scanned segment bus plus one-hot

---
 rtl/seg_scan_decoder.sv | 169 ++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_decoder
// Brief    : Snoops a scanned seven-segment bus and decodes each digit's
//            segment pattern back to its hex nibble.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_decoder #(
  parameter int NUM_DIGITS    = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [4*NUM_DIGITS-1:0] hex_out,
  output logic [NUM_DIGITS-1:0]   dp_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    frame_done,
  output logic                    err_pattern,
  output logic                    err_sel
);

  localparam int                    CW         = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0]         c_cnt_last = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0]         c_cnt_one  = CW'(1);
  localparam logic [NUM_DIGITS-1:0] c_sel_one  = NUM_DIGITS'(1);

  typedef enum logic [1:0] {
    ST_BLANK  = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  // Returns {legal, value}; dp is not part of the lookup.
  function automatic logic [4:0] f_decode(input logic [6:0] pat);
    logic [4:0] res;
    res = 5'h00;
    case (pat)
      7'h7E:   res = {1'b1, 4'h0};
      7'h30:   res = {1'b1, 4'h1};
      7'h6D:   res = {1'b1, 4'h2};
      7'h79:   res = {1'b1, 4'h3};
      7'h33:   res = {1'b1, 4'h4};
      7'h5B:   res = {1'b1, 4'h5};
      7'h5F:   res = {1'b1, 4'h6};
      7'h70:   res = {1'b1, 4'h7};
      7'h7F:   res = {1'b1, 4'h8};
      7'h7B:   res = {1'b1, 4'h9};
      7'h77:   res = {1'b1, 4'hA};
      7'h1F:   res = {1'b1, 4'hB};
      7'h0D:   res = {1'b1, 4'hC};
      7'h3D:   res = {1'b1, 4'hD};
      7'h4F:   res = {1'b1, 4'hE};
      7'h47:   res = {1'b1, 4'hF};
      default: res = 5'h00;
    endcase
    return res;
  endfunction

  logic [7:0]              r_seg_s1, r_seg_s2, r_held_seg;
  logic [NUM_DIGITS-1:0]   r_sel_s1, r_sel_s2, r_held_sel;
  state_t                  r_state, w_state_nx;
  logic [CW-1:0]           r_cnt, w_cnt_nx;
  logic [4*NUM_DIGITS-1:0] r_hex;
  logic [NUM_DIGITS-1:0]   r_dp, r_valid, r_seen;
  logic                    r_frame_done, r_err_pat, r_err_sel;

  logic                    w_changed, w_capture, w_multi;
  logic [4:0]              w_dec;
  logic [NUM_DIGITS-1:0]   w_seen_set;

  assign w_changed = (r_seg_s2 != r_held_seg) || (r_sel_s2 != r_held_sel);
  assign w_multi   = |(r_held_sel & (r_held_sel - c_sel_one));
  assign w_dec     = f_decode(r_held_seg[7:1]);
  // Illegal one-hot captures still count toward the frame.
  assign w_seen_set = (w_capture && !w_multi) ? r_held_sel : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_s1   <= '0;
      r_seg_s2   <= '0;
      r_sel_s1   <= '0;
      r_sel_s2   <= '0;
      r_held_seg <= '0;
      r_held_sel <= '0;
    end else begin
      r_seg_s1 <= seg_in;
      r_seg_s2 <= r_seg_s1;
      r_sel_s1 <= dig_sel;
      r_sel_s2 <= r_sel_s1;
      if (w_changed) begin
        r_held_seg <= r_seg_s2;
        r_held_sel <= r_sel_s2;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_BLANK;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_capture  = 1'b0;
    if (w_changed) begin
      w_cnt_nx   = '0;
      w_state_nx = (r_sel_s2 == '0) ? ST_BLANK : ST_SETTLE;
    end else begin
      case (r_state)
        ST_SETTLE: begin
          if (r_cnt == c_cnt_last) begin
            w_capture  = 1'b1;
            w_state_nx = ST_HOLD;
          end else begin
            w_cnt_nx = r_cnt + c_cnt_one;
          end
        end
        default: begin
          w_state_nx = r_state;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hex        <= '0;
      r_dp         <= '0;
      r_valid      <= '0;
      r_seen       <= '0;
      r_frame_done <= 1'b0;
      r_err_pat    <= 1'b0;
      r_err_sel    <= 1'b0;
    end else begin
      r_err_pat    <= w_capture && !w_multi && !w_dec[4];
      r_err_sel    <= w_capture && w_multi;
      r_frame_done <= &r_seen;
      r_seen       <= ((&r_seen) ? '0 : r_seen) | w_seen_set;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (w_capture && !w_multi && r_held_sel[i]) begin
          if (w_dec[4]) begin
            r_hex[4*i +: 4] <= w_dec[3:0];
            r_dp[i]         <= r_held_seg[0];
            r_valid[i]      <= 1'b1;
          end else begin
            r_valid[i] <= 1'b0;
          end
        end
      end
    end
  end

  assign hex_out     = r_hex;
  assign dp_out      = r_dp;
  assign digit_valid = r_valid;
  assign frame_done  = r_frame_done;
  assign err_pattern = r_err_pat;
  assign err_sel     = r_err_sel;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
`default_nettype none
// Directed and random stimulus for seg_scan_decoder, checked every clock against
// a run-length reference model of the capture rules.
module tb_seg_scan_decoder;
  localparam int NUM_DIGITS    = 8;
  localparam int STABLE_CYCLES = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  seg_in;
  logic [7:0]  dig_sel;
  logic [31:0] hex_out;
  logic [7:0]  dp_out;
  logic [7:0]  digit_valid;
  logic        frame_done;
  logic        err_pattern;
  logic        err_sel;

  always #5 clk = ~clk;

  seg_scan_decoder #(
    .NUM_DIGITS    (NUM_DIGITS),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .dig_sel     (dig_sel),
    .hex_out     (hex_out),
    .dp_out      (dp_out),
    .digit_valid (digit_valid),
    .frame_done  (frame_done),
    .err_pattern (err_pattern),
    .err_sel     (err_sel)
  );

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  logic [6:0]  c_pat [16];

  // Reference model state
  logic [31:0] m_hex;
  logic [7:0]  m_dp, m_valid, m_seen;
  logic        m_fd, m_ep, m_es;
  logic [7:0]  m_prev_seg, m_prev_sel;
  int          m_run;
  logic        d1_v, d2_v;
  logic [7:0]  d1_seg, d1_sel, d2_seg, d2_sel;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hex = '0; m_dp = '0; m_valid = '0; m_seen = '0;
    m_fd = 1'b0; m_ep = 1'b0; m_es = 1'b0;
    m_prev_seg = '0; m_prev_sel = '0; m_run = 0;
    d1_v = 1'b0; d2_v = 1'b0;
    d1_seg = '0; d1_sel = '0; d2_seg = '0; d2_sel = '0;
  endtask

  task automatic apply_capture(input logic [7:0] seg, input logic [7:0] sel);
    int idx;
    int val;
    if ($countones(sel) > 1) begin
      m_es = 1'b1;
    end else begin
      idx = 0;
      for (int i = 0; i < NUM_DIGITS; i++) if (sel[i]) idx = i;
      val = -1;
      for (int v = 0; v < 16; v++) if (c_pat[v] == seg[7:1]) val = v;
      m_seen[idx] = 1'b1;
      if (val >= 0) begin
        m_hex[4*idx +: 4] = val[3:0];
        m_dp[idx]         = seg[0];
        m_valid[idx]      = 1'b1;
      end else begin
        m_ep         = 1'b1;
        m_valid[idx] = 1'b0;
      end
    end
  endtask

  // A raw value seen on STABLE_CYCLES+1 consecutive edges is captured two edges later.
  task automatic model_step();
    m_fd = &m_seen;
    if (m_fd) m_seen = '0;
    m_ep = 1'b0;
    m_es = 1'b0;
    if (d2_v) apply_capture(d2_seg, d2_sel);
    d2_v = d1_v; d2_seg = d1_seg; d2_sel = d1_sel;
    if (seg_in == m_prev_seg && dig_sel == m_prev_sel) m_run++;
    else m_run = 1;
    m_prev_seg = seg_in;
    m_prev_sel = dig_sel;
    d1_v   = (m_run == STABLE_CYCLES + 1) && (dig_sel != 8'h00);
    d1_seg = seg_in;
    d1_sel = dig_sel;
  endtask

  task automatic check_outputs();
    check("hex_out",     hex_out,     m_hex);
    check("dp_out",      dp_out,      m_dp);
    check("digit_valid", digit_valid, m_valid);
    check("frame_done",  frame_done,  m_fd);
    check("err_pattern", err_pattern, m_ep);
    check("err_sel",     err_sel,     m_es);
  endtask

  task automatic tick(input logic [7:0] seg, input logic [7:0] sel);
    seg_in  = seg;
    dig_sel = sel;
    @(posedge clk);
    if (rst_n) model_step();
    else model_reset();
    #1;
    check_outputs();
  endtask

  int         n_pulses;
  int         n_ep, n_es;
  logic [7:0] r_seg, r_sel;
  int         dwell, a, b, kind;

  initial begin
    c_pat = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
              7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h0D, 7'h3D, 7'h4F, 7'h47};
    model_reset();
    rst_n   = 1'b0;
    seg_in  = 8'hFF;
    dig_sel = 8'h01;

    // T1: reset with an active bus, release onto a blank select
    repeat (3) tick(8'hFF, 8'h01);
    rst_n = 1'b1;
    n_pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick(8'hB6, 8'h00);
      n_pulses += int'(frame_done) + int'(err_pattern) + int'(err_sel);
    end
    check("t1_no_pulses", n_pulses, 0);

    // T2: single capture lands exactly six edges after first sample
    for (int i = 0; i < 20; i++) begin
      tick(8'hDA, 8'h04);
      if (i == 5) check("t2_before_nibble", {31'd0, digit_valid[2]}, 0);
      if (i == 6) begin
        check("t2_at_nibble", hex_out[11:8], 4'h2);
        check("t2_at_valid",  digit_valid[2], 1'b1);
        check("t2_at_dp",     dp_out[2], 1'b0);
      end
    end
    check("t2_hex_final", hex_out, 32'h0000_0200);

    // T4: illegal pattern on the same digit
    n_ep = 0;
    for (int i = 0; i < 12; i++) begin
      tick(8'h02, 8'h04);
      n_ep += int'(err_pattern);
    end
    check("t4_err_pattern_count", n_ep, 1);
    check("t4_valid_cleared", digit_valid, 8'h00);
    check("t4_nibble_kept", hex_out[11:8], 4'h2);

    // T5: multi-hot select
    n_es = 0;
    for (int i = 0; i < 10; i++) begin
      tick(8'hFC, 8'h05);
      n_es += int'(err_sel);
    end
    check("t5_err_sel_count", n_es, 1);
    check("t5_hex_unchanged", hex_out, 32'h0000_0200);
    check("t5_valid_unchanged", digit_valid, 8'h00);

    // T3: two full scans, one frame pulse each
    for (int s = 0; s < 2; s++) begin
      n_pulses = 0;
      for (int d = 0; d < NUM_DIGITS; d++) begin
        for (int i = 0; i < 8; i++) begin
          tick({c_pat[d], 1'b0}, 8'(1 << d));
          n_pulses += int'(frame_done);
        end
      end
      for (int i = 0; i < 2; i++) begin
        tick({c_pat[7], 1'b0}, 8'h80);
        n_pulses += int'(frame_done);
      end
      check("t3_hex_scan", hex_out, 32'h7654_3210);
      check("t3_valid_scan", digit_valid, 8'hFF);
      check("t3_frame_pulses", n_pulses, 1);
    end

    // Random dwell sequence
    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 9);
      a = $urandom_range(0, 7);
      b = (a + $urandom_range(1, 7)) % 8;
      if (kind == 0)      r_sel = 8'h00;
      else if (kind == 1) r_sel = 8'(1 << a) | 8'(1 << b);
      else                r_sel = 8'(1 << a);
      if ($urandom_range(0, 3) != 0) r_seg = {c_pat[$urandom_range(0, 15)], 1'($urandom_range(0, 1))};
      else                           r_seg = 8'($urandom);
      dwell = $urandom_range(1, 9);
      repeat (dwell) tick(r_seg, r_sel);
    end

    // T6: short glitch never captures
    repeat (10) tick({c_pat[10], 1'b1}, 8'h08);
    check("t6_nibble_a", hex_out[15:12], 4'hA);
    for (int i = 0; i < 3; i++) tick({c_pat[5], 1'b0}, 8'h08);
    for (int i = 0; i < 10; i++) begin
      tick({c_pat[10], 1'b1}, 8'h08);
      check("t6_glitch_ignored", hex_out[15:12], 4'hA);
    end

    // Asynchronous reset in the middle of a settle
    repeat (3) tick({c_pat[6], 1'b0}, 8'h08);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check("t6_async_hex", hex_out, 32'h0);
    repeat (2) tick({c_pat[6], 1'b0}, 8'h08);
    rst_n = 1'b1;
    n_pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick(8'h00, 8'h00);
      n_pulses += int'(frame_done) + int'(err_pattern) + int'(err_sel);
    end
    check("t6_no_pulses", n_pulses, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
